// File: rtl/rv_mc_ctrl_if.sv
// Purpose: control bundle between the multi-cycle controller and its datapath.
// Latency: wires only, no storage.
// Backpressure: imem_ready/dmem_ready flow from the datapath (slave) to the controller (master).
interface rv_mc_ctrl_if;
    // Instruction fields and datapath status
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       imem_ready;
    logic       dmem_ready;

    // Write strobes and status
    logic       ir_we;
    logic       pc_we;
    logic       reg_we;
    logic       mem_we;
    logic       mem_re;
    logic       halt;

    // Datapath selects
    logic [2:0] imm_op;
    logic [2:0] alu_op;
    logic [2:0] m4_1_cnt;
    logic [2:0] m4_2_cnt;
    logic [1:0] m2_1_cnt;
    logic [1:0] m2_2_cnt;
    logic [1:0] m2_3_cnt;
    logic [1:0] m2_4_cnt;
    logic [2:0] state;

    modport master (
        input  opcode, funct3, funct7_5, zero, imem_ready, dmem_ready,
        output ir_we, pc_we, reg_we, mem_we, mem_re, halt,
        output imm_op, alu_op, m4_1_cnt, m4_2_cnt,
        output m2_1_cnt, m2_2_cnt, m2_3_cnt, m2_4_cnt, state
    );

    modport slave (
        output opcode, funct3, funct7_5, zero, imem_ready, dmem_ready,
        input  ir_we, pc_we, reg_we, mem_we, mem_re, halt,
        input  imm_op, alu_op, m4_1_cnt, m4_2_cnt,
        input  m2_1_cnt, m2_2_cnt, m2_3_cnt, m2_4_cnt, state
    );
endinterface

// File: rtl/rv_mc_ctrl.sv
// Purpose: multi-cycle RV32I subset control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) for a shared-ALU datapath.
// Latency: ALU/branch/jump/lui 3 cycles, sw 4+N, lw 5+N (N = dmem_ready low cycles), plus imem_ready wait in FETCH.
// Backpressure: holds in FETCH while imem_ready=0 and in MEM while dmem_ready=0; TRAP absorbs until rst.
// Option: define INSTRET_CNT_EN to add the 32-bit retired-instruction counter output instret.
module rv_mc_ctrl (
    input  logic               clk,
    input  logic               rst,
    rv_mc_ctrl_if.master       bus
`ifdef INSTRET_CNT_EN
    ,
    output logic [31:0]        instret
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    // Opcodes accepted by DECODE
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    // Immediate format select
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    // ALU function select
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_XOR = 3'd5;

    // Next-PC source select
    localparam logic [2:0] PC_IMM   = 3'd0;
    localparam logic [2:0] PC_PLUS4 = 3'd1;
    localparam logic [2:0] PC_RES   = 3'd3;

    state_t     state_q, state_d;
    logic [6:0] op_q;
    logic [2:0] f3_q;
    logic       f7_q;

    logic       ir_we, pc_we, reg_we, mem_we, mem_re, halt;
    logic [2:0] imm_op, alu_op, m4_1_cnt, m4_2_cnt;
    logic [1:0] m2_1_cnt, m2_2_cnt, m2_4_cnt;

    // Instruction class from the latched opcode only; live inputs are ignored after FETCH
    logic is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr, is_lui, is_legal;
    assign is_r     = (op_q == OP_R);
    assign is_i     = (op_q == OP_I);
    assign is_lw    = (op_q == OP_LW);
    assign is_sw    = (op_q == OP_SW);
    assign is_br    = (op_q == OP_BR);
    assign is_jal   = (op_q == OP_JAL);
    assign is_jalr  = (op_q == OP_JALR);
    assign is_lui   = (op_q == OP_LUI);
    assign is_legal = is_r | is_i | is_lw | is_sw | is_br | is_jal | is_jalr | is_lui;

    // beq/bne are the only branch forms; a taken branch selects pc+imm
    logic br_ok, br_take;
    assign br_ok   = (f3_q == 3'b000) || (f3_q == 3'b001);
    assign br_take = ((f3_q == 3'b000) &&  bus.zero) ||
                     ((f3_q == 3'b001) && !bus.zero);

    // ALU function for register/immediate arithmetic; sub only exists in the R form
    logic [2:0] alu_fn;
    always_comb begin
        alu_fn = ALU_ADD;
        case (f3_q)
            3'b000:  alu_fn = (is_r && f7_q) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_fn = ALU_AND;
            3'b110:  alu_fn = ALU_OR;
            3'b010:  alu_fn = ALU_SLT;
            3'b100:  alu_fn = ALU_XOR;
            default: alu_fn = ALU_ADD;
        endcase
    end

    // State register; reset always restarts the sequence at FETCH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction field latch, loaded on the single ir_we cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q <= '0;
            f3_q <= '0;
            f7_q <= 1'b0;
        end else if (ir_we) begin
            op_q <= bus.opcode;
            f3_q <= bus.funct3;
            f7_q <= bus.funct7_5;
        end
    end

    // Next state and control decode; reset forces every control low without a clock
    always_comb begin
        state_d  = state_q;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        reg_we   = 1'b0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        halt     = 1'b0;
        imm_op   = IMM_I;
        alu_op   = ALU_ADD;
        m4_1_cnt = PC_IMM;
        m4_2_cnt = 3'd0;
        m2_1_cnt = 2'd0;
        m2_2_cnt = 2'd0;
        m2_4_cnt = 2'd0;

        case (state_q)
            S_FETCH: begin
                if (bus.imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                state_d = is_legal ? S_EXEC : S_TRAP;
            end

            S_EXEC: begin
                if (is_r || is_i) begin
                    alu_op   = alu_fn;
                    m2_1_cnt = is_i ? 2'd1 : 2'd0;
                    reg_we   = 1'b1;
                    pc_we    = 1'b1;
                    m4_1_cnt = PC_PLUS4;
                    state_d  = S_FETCH;
                end else if (is_lw || is_sw) begin
                    imm_op   = is_sw ? IMM_S : IMM_I;
                    alu_op   = ALU_ADD;
                    m2_1_cnt = 2'd1;
                    state_d  = S_MEM;
                end else if (is_br) begin
                    imm_op = IMM_B;
                    alu_op = ALU_SUB;
                    if (br_ok) begin
                        pc_we    = 1'b1;
                        m4_1_cnt = br_take ? PC_IMM : PC_PLUS4;
                        state_d  = S_FETCH;
                    end else begin
                        state_d  = S_TRAP;
                    end
                end else if (is_jal) begin
                    imm_op   = IMM_J;
                    m2_2_cnt = 2'd1;
                    reg_we   = 1'b1;
                    pc_we    = 1'b1;
                    m4_1_cnt = PC_IMM;
                    state_d  = S_FETCH;
                end else if (is_jalr) begin
                    imm_op   = IMM_I;
                    m2_1_cnt = 2'd1;
                    alu_op   = ALU_ADD;
                    m2_2_cnt = 2'd1;
                    reg_we   = 1'b1;
                    pc_we    = 1'b1;
                    m4_1_cnt = PC_RES;
                    state_d  = S_FETCH;
                end else if (is_lui) begin
                    imm_op   = IMM_U;
                    m2_4_cnt = 2'd1;
                    reg_we   = 1'b1;
                    pc_we    = 1'b1;
                    m4_1_cnt = PC_PLUS4;
                    state_d  = S_FETCH;
                end else begin
                    // DECODE never lets an illegal opcode in; trap defensively anyway
                    state_d = S_TRAP;
                end
            end

            S_MEM: begin
                if (is_lw) begin
                    mem_re = 1'b1;
                    if (bus.dmem_ready) begin
                        state_d = S_WB;
                    end
                end else if (bus.dmem_ready) begin
                    // Store strobe and retire share the completion cycle
                    mem_we   = 1'b1;
                    pc_we    = 1'b1;
                    m4_1_cnt = PC_PLUS4;
                    state_d  = S_FETCH;
                end
            end

            S_WB: begin
                m4_2_cnt = 3'd1;
                reg_we   = 1'b1;
                pc_we    = 1'b1;
                m4_1_cnt = PC_PLUS4;
                state_d  = S_FETCH;
            end

            S_TRAP: begin
                halt    = 1'b1;
                state_d = S_TRAP;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (!rst) begin
            state_d  = S_FETCH;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            reg_we   = 1'b0;
            mem_we   = 1'b0;
            mem_re   = 1'b0;
            halt     = 1'b0;
            imm_op   = 3'd0;
            alu_op   = 3'd0;
            m4_1_cnt = 3'd0;
            m4_2_cnt = 3'd0;
            m2_1_cnt = 2'd0;
            m2_2_cnt = 2'd0;
            m2_4_cnt = 2'd0;
        end
    end

    assign bus.ir_we    = ir_we;
    assign bus.pc_we    = pc_we;
    assign bus.reg_we   = reg_we;
    assign bus.mem_we   = mem_we;
    assign bus.mem_re   = mem_re;
    assign bus.halt     = halt;
    assign bus.imm_op   = imm_op;
    assign bus.alu_op   = alu_op;
    assign bus.m4_1_cnt = m4_1_cnt;
    assign bus.m4_2_cnt = m4_2_cnt;
    assign bus.m2_1_cnt = m2_1_cnt;
    assign bus.m2_2_cnt = m2_2_cnt;
    assign bus.m2_3_cnt = 2'b00;
    assign bus.m2_4_cnt = m2_4_cnt;
    assign bus.state    = state_q;

`ifdef INSTRET_CNT_EN
    logic [31:0] instret_q;

    // Retired-instruction count: one pc_we per retire, wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_q <= '0;
        end else if (pc_we) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`endif

endmodule
